// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI bridge: FSM encodings,
// single-beat AXI constants and the write-strobe decode.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_B    = 2'd2
  } wstate_t;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_ID_INST    = 4'd0;
  localparam logic [3:0] AXI_ID_DATA    = 4'd1;

  // SRAM-like size code (0/1/2 = 1/2/4 bytes) maps directly onto AXI size
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

  // Byte lanes touched by an access of the given size at the given offset
  function automatic logic [3:0] wstrb_decode(input logic [1:0] size,
                                              input logic [1:0] offset);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << offset;
      2'd1:    strb = 4'b0011 << offset;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_like_axi_bridge.sv
// Bridges an instruction and a data SRAM-like port onto one AXI master.
// Independent read and write FSMs, one transaction outstanding on each,
// all bursts single-beat. Data reads hitting the in-flight write word wait.
module sram_like_axi_bridge
  import axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rstate_t r_state;
  wstate_t w_state;
  logic    r_owner_data;
  logic    data_ok_pend;

  logic data_rd_req, data_wr_req, raw_hazard;
  logic rd_data_go, rd_inst_go, wr_go;
  logic r_hs, b_hs;

  // Read-only inst port, single ID space and ignored responses
  logic unused_inputs;
  assign unused_inputs = ^{inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp};

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign awid    = AXI_ID_DATA;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = AXI_ID_DATA;
  assign wlast   = 1'b1;

  assign r_hs = rready & rvalid;
  assign b_hs = bready & bvalid;

  // Request arbitration: data read beats inst, reads to the pending write word wait
  always_comb begin
    data_rd_req  = data_req & ~data_wr;
    data_wr_req  = data_req & data_wr;
    raw_hazard   = (w_state != W_IDLE) && (data_addr[31:2] == awaddr[31:2]);
    rd_data_go   = (r_state == R_IDLE) && data_rd_req && !raw_hazard;
    rd_inst_go   = (r_state == R_IDLE) && inst_req && !rd_data_go;
    wr_go        = (w_state == W_IDLE) && data_wr_req;
    inst_addr_ok = rd_inst_go;
    data_addr_ok = rd_data_go | wr_go;
  end

  // Read FSM: latch owner and AR payload, run AR then R, capture rdata
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= R_IDLE;
      r_owner_data <= 1'b0;
      arid         <= '0;
      araddr       <= '0;
      arsize       <= '0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rd_data_go || rd_inst_go) begin
            r_owner_data <= rd_data_go;
            arid         <= rd_data_go ? AXI_ID_DATA : AXI_ID_INST;
            araddr       <= rd_data_go ? data_addr : inst_addr;
            arsize       <= axi_size(rd_data_go ? data_size : inst_size);
            arvalid      <= 1'b1;
            r_state      <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (r_owner_data) data_rdata <= rdata;
            else              inst_rdata <= rdata;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW and W issued together, each dropped on its own handshake
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      awaddr  <= '0;
      awsize  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_go) begin
            awaddr  <= data_addr;
            awsize  <= axi_size(data_size);
            wdata   <= data_wdata;
            wstrb   <= wstrb_decode(data_size, data_addr[1:0]);
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            w_state <= W_REQ;
          end
        end
        W_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            w_state <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            bready  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Completion pulses; a data read and a write finishing together are
  // reported on consecutive cycles so the data port sees both.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      data_ok_pend <= 1'b0;
    end else begin
      inst_data_ok <= r_hs & ~r_owner_data;
      data_data_ok <= (r_hs & r_owner_data) | b_hs | data_ok_pend;
      data_ok_pend <= r_hs & r_owner_data & b_hs;
    end
  end

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Bench for sram_like_axi_bridge: AXI slave with configurable latencies,
// a word-level reference memory and directed plus randomized accesses.
module tb_sram_like_axi_bridge;

  logic        clk, resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, rid, awid, wid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_like_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0, failures = 0, cyc = 0;
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int ar_bad = 0, aw_bad = 0, w_bad = 0;
  int r_hs_cyc = 0, b_hs_cyc = 0;
  int aw_hs_cnt = 0, b_hs_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [3:0]  last_arid, last_wstrb;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [2:0]  last_arsize, last_awsize;
  logic [3:0]  arid_q [$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] smem    [logic [29:0]];

  // Contents of a word never written
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[31:2] == 30'h2FF00000) return 32'h3C1DBFC0;
    return {a[31:2], 2'b01} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word(a);
  endfunction

  function automatic logic [31:0] smem_rd(input logic [31:0] a);
    if (smem.exists(a[31:2])) return smem[a[31:2]];
    return init_word(a);
  endfunction

  // Reference write: the master places bytes on their natural lanes
  task automatic ref_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    int lane;
    w = ref_rd(a);
    for (int k = 0; k < (1 << sz); k++) begin
      lane = int'(a[1:0]) + k;
      w[lane*8 +: 8] = wd[lane*8 +: 8];
    end
    ref_mem[a[31:2]] = w;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resetn && awvalid && awready) aw_hs_cnt <= aw_hs_cnt + 1;
    if (resetn && bvalid && bready)   b_hs_cnt  <= b_hs_cnt + 1;
  end

  // AXI read slave
  initial begin
    logic [31:0] a0; logic [3:0] i0; logic [2:0] s0; bit hs;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    forever begin
      tick();
      if (resetn && arvalid) begin
        a0 = araddr; i0 = arid; s0 = arsize;
        for (int i = 0; i < ar_delay; i++) begin
          tick();
          if (!arvalid || araddr !== a0 || arid !== i0 || arsize !== s0) ar_bad++;
        end
        if (arlen !== 8'd0 || arburst !== 2'b01 || arlock !== 2'd0 ||
            arcache !== 4'd0 || arprot !== 3'd0) ar_bad++;
        arready = 1;
        last_arid = arid; last_araddr = araddr; last_arsize = arsize;
        arid_q.push_back(arid);
        tick();
        arready = 0;
        for (int i = 0; i < r_delay; i++) tick();
        rvalid = 1; rdata = smem_rd(last_araddr); rid = last_arid; rlast = 1;
        rresp = 2'($urandom_range(0, 3));
        hs = 0;
        for (int i = 0; i < 60 && !hs; i++) begin
          @(negedge clk);
          if (rready) begin hs = 1; r_hs_cyc = cyc; end
          tick();
        end
        rvalid = 0; rlast = 0;
      end
    end
  end

  // AXI write-address slave
  initial begin
    logic [31:0] a0; logic [2:0] s0;
    awready = 0;
    forever begin
      tick();
      if (resetn && awvalid) begin
        a0 = awaddr; s0 = awsize;
        for (int i = 0; i < aw_delay; i++) begin
          tick();
          if (!awvalid || awaddr !== a0 || awsize !== s0) aw_bad++;
        end
        if (awlen !== 8'd0 || awburst !== 2'b01 || awlock !== 2'd0 ||
            awcache !== 4'd0 || awprot !== 3'd0) aw_bad++;
        awready = 1;
        last_awaddr = awaddr; last_awsize = awsize;
        tick();
        awready = 0;
        aw_cnt++;
      end
    end
  end

  // AXI write-data slave, updates the slave memory through wstrb
  initial begin
    logic [31:0] d0, w0; logic [3:0] st0;
    wready = 0;
    forever begin
      tick();
      if (resetn && wvalid) begin
        d0 = wdata; st0 = wstrb;
        for (int i = 0; i < w_delay; i++) begin
          tick();
          if (!wvalid || wdata !== d0 || wstrb !== st0) w_bad++;
        end
        if (wlast !== 1'b1) w_bad++;
        wready = 1;
        last_wdata = wdata; last_wstrb = wstrb;
        w0 = smem_rd(awaddr);
        for (int b = 0; b < 4; b++) if (wstrb[b]) w0[b*8 +: 8] = wdata[b*8 +: 8];
        smem[awaddr[31:2]] = w0;
        tick();
        wready = 0;
        w_cnt++;
      end
    end
  end

  // AXI write-response slave, answers once both AW and W are accepted
  initial begin
    int served; bit hs;
    served = 0;
    bvalid = 0; bid = 0; bresp = 0;
    forever begin
      tick();
      if (aw_cnt > served && w_cnt > served) begin
        served++;
        for (int i = 0; i < b_delay; i++) tick();
        bvalid = 1; bid = 4'd1; bresp = 2'($urandom_range(0, 3));
        hs = 0;
        for (int i = 0; i < 60 && !hs; i++) begin
          @(negedge clk);
          if (bready) begin hs = 1; b_hs_cyc = cyc; end
          tick();
        end
        bvalid = 0;
      end
    end
  end

  task automatic data_issue(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
    bit got;
    got = 0;
    data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (data_addr_ok) got = 1;
      tick();
    end
    data_req = 0;
    check("data_addr_ok", 32'(got), 32'd1);
  endtask

  task automatic inst_issue(input logic [31:0] a, input logic [1:0] sz);
    bit got;
    got = 0;
    inst_req = 1; inst_addr = a; inst_size = sz; inst_wdata = $urandom;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (inst_addr_ok) got = 1;
      tick();
    end
    inst_req = 0;
    check("inst_addr_ok", 32'(got), 32'd1);
  endtask

  task automatic wait_ok(input bit is_data, output int okc);
    bit got;
    got = 0; okc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (is_data ? data_data_ok : inst_data_ok) begin got = 1; okc = cyc; end
      tick();
    end
    check(is_data ? "data_ok_seen" : "inst_ok_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("ok_pulse_width", 32'(is_data ? data_data_ok : inst_data_ok), 32'd0);
    tick();
  endtask

  task automatic read_checks(input bit is_data, input logic [31:0] a, input logic [1:0] sz,
                             input int okc);
    check(is_data ? "data_rdata" : "inst_rdata", is_data ? data_rdata : inst_rdata, ref_rd(a));
    check("arid", 32'(last_arid), is_data ? 32'd1 : 32'd0);
    check("araddr", last_araddr, a);
    check("arsize", 32'(last_arsize), 32'(sz));
    check("r_to_ok", 32'(okc), 32'(r_hs_cyc + 1));
    check("ar_protocol", 32'(ar_bad), 32'd0);
  endtask

  task automatic write_checks(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                              input int okc);
    logic [3:0] es;
    es = 4'(((1 << (1 << sz)) - 1) << a[1:0]);
    check("wstrb", 32'(last_wstrb), 32'(es));
    check("awsize", 32'(last_awsize), 32'(sz));
    check("awaddr", last_awaddr, a);
    check("wdata", last_wdata, wd);
    check("b_to_ok", 32'(okc), 32'(b_hs_cyc + 1));
    check("aw_w_protocol", 32'(aw_bad + w_bad), 32'd0);
    ref_write(a, sz, wd);
  endtask

  task automatic do_data(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    int okc;
    data_issue(wr, sz, a, wd);
    wait_ok(1'b1, okc);
    if (wr) write_checks(a, sz, wd, okc);
    else    read_checks(1'b1, a, sz, okc);
  endtask

  task automatic do_inst(input logic [31:0] a, input logic [1:0] sz);
    int okc;
    inst_issue(a, sz);
    wait_ok(1'b0, okc);
    read_checks(1'b0, a, sz, okc);
  endtask

  initial begin
    int okc, early, n0, bc0, b_at, wokc, aw0, op, cnt;
    bit got, wok, inst_acc, seen;
    logic [31:0] a, wd;
    logic [1:0] sz;

    resetn = 0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    repeat (3) tick();

    // reset state
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    check("rst_rdata", inst_rdata | data_rdata, 32'd0);
    check("rst_awaddr_wdata", awaddr | wdata, 32'd0);
    resetn = 1;
    tick();

    // inst fetch from the boot vector, arready after 2 cycles
    ar_delay = 2; r_delay = 1;
    do_inst(32'hBFC00000, 2'd2);
    check("boot_word", inst_rdata, 32'h3C1DBFC0);

    // inst and data read together: data wins, inst waits for data completion
    ar_delay = 1; r_delay = 2;
    n0 = arid_q.size();
    inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2'd2;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80001000;
    @(negedge clk);
    check("prio_data_addr_ok", 32'(data_addr_ok), 32'd1);
    check("prio_inst_blocked", 32'(inst_addr_ok), 32'd0);
    tick();
    data_req = 0;
    early = 0; got = 0; inst_acc = 0; okc = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (data_data_ok) begin got = 1; okc = cyc; inst_acc = inst_addr_ok; end
      else if (inst_addr_ok) early++;
      tick();
    end
    check("prio_data_ok", 32'(got), 32'd1);
    check("prio_inst_early", 32'(early), 32'd0);
    check("prio_data_rdata", data_rdata, ref_rd(32'h80001000));
    check("prio_r_to_ok", 32'(okc), 32'(r_hs_cyc + 1));
    if (inst_acc) inst_req = 0;
    else inst_issue(32'hBFC00000, 2'd2);
    wait_ok(1'b0, okc);
    check("prio_inst_rdata", inst_rdata, 32'h3C1DBFC0);
    check("prio_ar_count", 32'(arid_q.size()), 32'(n0 + 2));
    check("prio_first_id", 32'(arid_q[n0]), 32'd1);
    check("prio_second_id", 32'(arid_q[n0 + 1]), 32'd0);

    // byte write to the top lane
    aw_delay = 1; w_delay = 0; b_delay = 2;
    do_data(1'b1, 2'd0, 32'h80000003, 32'h000000AB);
    check("byte_wstrb", 32'(last_wstrb), 32'h8);

    // wready three cycles after awready: W held, AW not repeated
    aw_delay = 0; w_delay = 3; b_delay = 1;
    aw0 = aw_hs_cnt;
    wd = $urandom;
    data_issue(1'b1, 2'd2, 32'h80000020, wd);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wlag_awvalid", 32'(awvalid), 32'd0);
      check("wlag_wvalid", 32'(wvalid), 32'd1);
      check("wlag_bready", 32'(bready), 32'd0);
    end
    tick();
    check("wlag_wvalid_done", 32'(wvalid), 32'd0);
    check("wlag_bready_on", 32'(bready), 32'd1);
    wait_ok(1'b1, okc);
    write_checks(32'h80000020, 2'd2, wd, okc);
    check("wlag_aw_once", 32'(aw_hs_cnt - aw0), 32'd1);

    // read to the word being written is held until the write completes
    aw_delay = 0; w_delay = 0; b_delay = 8; ar_delay = 0; r_delay = 0;
    bc0 = b_hs_cnt;
    data_issue(1'b1, 2'd2, 32'h80000010, 32'h12345678);
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80000010;
    got = 0; wok = 0; b_at = -1; wokc = -1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (data_data_ok && !wok) begin wok = 1; wokc = cyc; end
      if (data_addr_ok) begin got = 1; b_at = b_hs_cnt; end
      tick();
    end
    data_req = 0;
    check("raw_addr_ok", 32'(got), 32'd1);
    check("raw_held_until_b", 32'(b_at), 32'(bc0 + 1));
    check("raw_write_ok", 32'(wok), 32'd1);
    check("raw_b_to_ok", 32'(wokc), 32'(b_hs_cyc + 1));
    ref_write(32'h80000010, 2'd2, 32'h12345678);
    wait_ok(1'b1, okc);
    read_checks(1'b1, 32'h80000010, 2'd2, okc);

    // randomized mix against the reference memory
    for (int n = 0; n < 40; n++) begin
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 2));
      a  = 32'h80000100 + 32'($urandom_range(0, 7) << 2);
      if (sz == 2'd0)      a = a + 32'($urandom_range(0, 3));
      else if (sz == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
      wd = $urandom;
      case (op)
        0:       do_inst(a, sz);
        1:       do_data(1'b0, sz, a, wd);
        default: do_data(1'b1, sz, a, wd);
      endcase
    end

    // reset while waiting for R: the read is dropped silently
    ar_delay = 0; r_delay = 30;
    data_issue(1'b0, 2'd2, 32'h80000104, 32'd0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (rready) seen = 1;
    end
    check("rst_mid_rdata_phase", 32'(seen), 32'd1);
    resetn = 0;
    tick();
    check("rst_mid_rready", 32'(rready), 32'd0);
    check("rst_mid_arvalid", 32'(arvalid), 32'd0);
    check("rst_mid_rdata", inst_rdata | data_rdata, 32'd0);
    resetn = 1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_data_ok || inst_data_ok || rready) cnt++;
    end
    check("rst_mid_no_ok", 32'(cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
